// File: rtl/synch_rom_pkg.sv
// Purpose  : shared types and default widths for the synchronous ROM reader.
// Latency  : n/a (types only).
// Backpres.: n/a.
// Contents : rd_state_t burst FSM encoding; default ADDR_W/DATA_W/FIFO_DEPTH.
package synch_rom_pkg;

  localparam int DEF_ADDR_W     = 4;
  localparam int DEF_DATA_W     = 4;
  localparam int DEF_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/synch_rom_reader_if.sv
// Purpose  : bundles the burst command, ROM read port and output stream of the reader.
// Latency  : n/a (wires only).
// Backpres.: out_valid/out_ready stream; command side uses busy/done.
// Ports    : master = reader side, slave = ROM/consumer/controller side.
//            checksum exists only when RD_CHECKSUM_EN is defined.
interface synch_rom_reader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
`ifdef RD_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;

  modport master (
    input  start, start_addr, len, rom_data, out_ready,
    output busy, done, rom_en, rom_addr, out_data, out_valid, checksum
  );
  modport slave (
    output start, start_addr, len, rom_data, out_ready,
    input  busy, done, rom_en, rom_addr, out_data, out_valid, checksum
  );
`else
  modport master (
    input  start, start_addr, len, rom_data, out_ready,
    output busy, done, rom_en, rom_addr, out_data, out_valid
  );
  modport slave (
    output start, start_addr, len, rom_data, out_ready,
    input  busy, done, rom_en, rom_addr, out_data, out_valid
  );
`endif
endinterface

// File: rtl/rd_fifo.sv
// Purpose  : DEPTH x W synchronous FIFO with occupancy count, head word shown combinationally.
// Latency  : push visible at head the cycle after the push.
// Backpres.: none internally; the writer must never push into a full FIFO unless popping.
// Ports    : clk, rst (async high), push/push_dat, pop, head, count.
module rd_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= nxt(wptr);
      if (pop)  rptr <= nxt(rptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the count alone says which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_dat;
  end

  assign head = mem[rptr];

endmodule

// File: rtl/synch_rom_reader.sv
// Purpose  : streams a (start_addr, len) burst out of a registered-output ROM, in order.
// Latency  : start cycle 0, rom_en cycle 1, out_valid cycle 3; then 1 word/cycle.
// Backpres.: reads stop once FIFO_DEPTH words are buffered or in flight; no loss.
// Ports    : clk, rst (async high), bus (synch_rom_reader_if.master).
//            Optional RD_CHECKSUM_EN: bus.checksum = XOR of words popped in the burst.
module synch_rom_reader
  import synch_rom_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  synch_rom_reader_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   remaining_q;
  logic              inflight_q;
  logic [CW-1:0]     count;
  logic              pop;
  logic              issue;
  logic              accept;
  logic [CW:0]       occupancy;

  assign pop    = bus.out_valid & bus.out_ready;
  assign accept = (state_q == IDLE) & bus.start;

  // Slots already committed after this cycle's pop; a new read may be
  // issued only if it still fits, so the FIFO can never overflow.
  assign occupancy = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign issue     = (state_q == READ) && (remaining_q != '0) &&
                     (occupancy < (CW+1)'(FIFO_DEPTH));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.start) state_d = (bus.len != '0) ? READ : DONE;
      READ:  if (issue && remaining_q == (ADDR_W+1)'(1)) state_d = DRAIN;
      // Leave as soon as the final word is being popped so done lands
      // in the cycle right after that pop.
      DRAIN: if (!inflight_q && (count == CW'(pop))) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (accept && bus.len != '0) begin
        addr_q      <= bus.start_addr;
        remaining_q <= bus.len;
      end else if (issue) begin
        addr_q      <= addr_q + ADDR_W'(1);
        remaining_q <= remaining_q - (ADDR_W+1)'(1);
      end
    end
  end

  rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W),
    .CW    (CW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight_q),
    .push_dat (bus.rom_data),
    .pop      (pop),
    .head     (bus.out_data),
    .count    (count)
  );

  assign bus.rom_en    = issue;
  assign bus.rom_addr  = addr_q;
  assign bus.out_valid = (count != '0);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);

`ifdef RD_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         checksum_q <= '0;
    else if (accept) checksum_q <= '0;
    else if (pop)    checksum_q <= checksum_q ^ bus.out_data;
  end

  assign bus.checksum = checksum_q;
`endif

endmodule

// File: tb/tb_synch_rom_reader.sv
module tb_synch_rom_reader;
  import synch_rom_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  synch_rom_reader_if #(.ADDR_W(4), .DATA_W(4)) bus ();

  synch_rom_reader #(.ADDR_W(4), .DATA_W(4), .FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ROM model: registered read, mem[a] = ~a
  always_ff @(posedge clk) begin
    if (bus.rom_en) bus.rom_data <= ~bus.rom_addr;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_q(input string tag, input logic [3:0] got[$], input logic [3:0] exp[$]);
    logic [3:0] g;
    chk({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      g = (i < got.size()) ? got[i] : 4'hx;
      chk($sformatf("%s[%0d]", tag, i), g, exp[i]);
    end
  endtask

  // Burst observations
  logic [3:0] got_data[$];
  logic [3:0] got_addr[$];
  int first_valid, first_pop, last_pop, done_cyc, done_cnt, en_cnt, en_stall;
  logic busy_c1;
  logic [3:0] chk_done;

  // Cycle 0 is the cycle start is held; stall = cycles with out_ready=0 from cycle 0.
  // poke re-asserts start (len=3, addr=7) in cycle 1, where it must be ignored.
  task automatic run_burst(input logic [3:0] sa, input logic [4:0] n, input int stall, input bit poke);
    int cyc;
    got_data.delete();
    got_addr.delete();
    first_valid = -1; first_pop = -1; last_pop = -1; done_cyc = -1;
    done_cnt = 0; en_cnt = 0; en_stall = 0; busy_c1 = 1'b0; chk_done = 4'hx;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.start_addr = sa; bus.len = n;
    bus.out_ready = (stall == 0);
    cyc = 0;
    while (cyc < 100 && !(done_cnt > 0 && cyc > done_cyc + 2)) begin
      @(negedge clk);
      if (bus.rom_en) begin
        en_cnt++;
        got_addr.push_back(bus.rom_addr);
        if (cyc < stall) en_stall++;
      end
      if (bus.out_valid && first_valid < 0) first_valid = cyc;
      if (bus.out_valid && bus.out_ready) begin
        got_data.push_back(bus.out_data);
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
`ifdef RD_CHECKSUM_EN
        chk_done = bus.checksum;
`endif
      end
      if (cyc == 1) busy_c1 = bus.busy;
      @(posedge clk); #1;
      cyc++;
      bus.start = poke && (cyc == 1);
      if (poke && cyc == 1) begin
        bus.start_addr = 4'h7;
        bus.len = 5'd3;
      end
      bus.out_ready = (cyc >= stall);
    end
    if (cyc >= 100) chk("burst_timeout", 1, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.start_addr = '0; bus.len = '0; bus.out_ready = 1'b0;
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rom_en", bus.rom_en, 0);
    chk("rst_rom_addr", bus.rom_addr, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    @(posedge clk); #1; rst = 1'b0;

    // 1: straight burst
    run_burst(4'h0, 5'd8, 0, 1'b0);
    chk_q("t1_data", got_data, '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8});
    chk("t1_first_valid", first_valid, 3);
    chk("t1_back_to_back", last_pop - first_pop, 7);
    chk("t1_done_after_pop", done_cyc, last_pop + 1);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_busy_c1", busy_c1, 1);
    chk("t1_en_cnt", en_cnt, 8);
`ifdef RD_CHECKSUM_EN
    chk("t1_checksum", chk_done, 4'h0);
`endif

    // 2: address wrap
    run_burst(4'hE, 5'd4, 0, 1'b0);
    chk_q("t2_addr", got_addr, '{4'hE, 4'hF, 4'h0, 4'h1});
    chk_q("t2_data", got_data, '{4'h1, 4'h0, 4'hF, 4'hE});

    // 3: backpressure, plus a start while busy
    run_burst(4'h2, 5'd6, 10, 1'b1);
    chk("t3_en_in_stall", en_stall, 2);
    chk_q("t3_data", got_data, '{4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8});
    chk("t3_en_cnt", en_cnt, 6);
    chk("t3_done_cnt", done_cnt, 1);
`ifdef RD_CHECKSUM_EN
    chk("t3_checksum", chk_done, 4'h1);
`endif

    // 4: len=0, start re-asserted during the done cycle
    run_burst(4'h3, 5'd0, 0, 1'b1);
    chk("t4_done_cyc", done_cyc, 1);
    chk("t4_en_cnt", en_cnt, 0);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_valid_never", first_valid, 32'hFFFF_FFFF);
`ifdef RD_CHECKSUM_EN
    chk("t4_checksum", chk_done, 4'h0);
`endif

    // 5: reset in the middle of a burst
    @(posedge clk); #1;
    bus.start = 1'b1; bus.start_addr = 4'h0; bus.len = 5'd8; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_busy_before", bus.busy, 1);
    chk("t5_valid_before", bus.out_valid, 1);
    rst = 1'b1;
    #1;
    chk("t5_rom_en_rst", bus.rom_en, 0);
    chk("t5_out_valid_rst", bus.out_valid, 0);
    chk("t5_busy_rst", bus.busy, 0);
    chk("t5_done_rst", bus.done, 0);
    @(posedge clk); #1; rst = 1'b0;
    run_burst(4'h5, 5'd1, 0, 1'b0);
    chk_q("t5_data", got_data, '{4'hA});
    chk("t5_first_valid", first_valid, 3);
    chk("t5_done_cnt", done_cnt, 1);
`ifdef RD_CHECKSUM_EN
    chk("t5_checksum", chk_done, 4'hA);

    // 6: checksum of F^E^D^C
    run_burst(4'h0, 5'd4, 0, 1'b0);
    chk("t6_checksum", chk_done, 4'h0);
    chk("t6_done_cnt", done_cnt, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
